checkfr_param_fsm: RTL

//  Parametrised successor of the single-precision fraction checker: decides whether an IEEE-754

---
 rtl/checkfr_param_fsm.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/checkfr_param_fsm.sv
// -----------------------------------------------------------------------------
// checkfr_param_fsm
//   Serial classifier that decides whether an IEEE-754 style operand of
//   configurable exponent/mantissa width has a non-zero fractional part.
//   The mantissa is scanned SCAN_W bits per cycle, LSB first, to find its
//   lowest set bit L. The decision then compares L against the number of
//   fraction bits left after the unbiased exponent s = E - B is applied.
//
//   Latency is fixed: r_o pulses N+2 edges after the accepting edge, where
//   N = ceil(MAN_W/SCAN_W). DECIDE takes two cycles. The first registers
//   the s / L comparisons and the second forms the result, so no
//   subtract-and-compare chain feeds the output flops directly.
//
// Parameters
//   EXP_W   exponent width (bias B = 2^(EXP_W-1)-1)
//   MAN_W   mantissa width
//   SCAN_W  mantissa bits examined per SCAN cycle (1..MAN_W)
//
// Ports
//   clk      clock, posedge
//   rst      synchronous active-high reset
//   num_in   operand {sign, exp, mantissa}, sampled on accept
//   r_i      start request, accepted in IDLE
//   busy     high while in SCAN or DECIDE
//   r_o      one-cycle result-valid pulse
//   res      1 = operand has a fractional part (held until next result)
//   is_zero  1 = operand is +/-0 (held with res)
//   is_inf   (CHECKFR_CLASS_EN only) exponent all-ones, mantissa zero
//   is_nan   (CHECKFR_CLASS_EN only) exponent all-ones, mantissa non-zero
//
// Build option
//   CHECKFR_CLASS_EN  adds is_inf/is_nan and forces res=0 for inf/NaN.
// -----------------------------------------------------------------------------
module checkfr_param_fsm #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int SCAN_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   num_in,
  input  logic                   r_i,
  output logic                   busy,
  output logic                   r_o,
  output logic                   res,
`ifdef CHECKFR_CLASS_EN
  output logic                   is_inf,
  output logic                   is_nan,
`endif
  output logic                   is_zero
);

  localparam int N  = (MAN_W + SCAN_W - 1) / SCAN_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = (SCAN_W > 1) ? $clog2(SCAN_W) : 1;
  localparam int LW = $clog2(MAN_W + SCAN_W);
  localparam int DW = (((EXP_W + 1) > LW) ? (EXP_W + 1) : LW) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SCAN   = 2'd1;
  localparam logic [1:0] ST_DECIDE = 2'd2;

  localparam logic [EXP_W-1:0] BIAS     = {1'b0, {(EXP_W-1){1'b1}}};
  localparam logic [IW-1:0]    IDX_LAST = IW'(N - 1);
  localparam logic [LW-1:0]    STEP     = LW'(SCAN_W);
  localparam logic [DW-1:0]    MAN_W_D  = DW'(MAN_W);

  logic [1:0]       state_r;
  logic [EXP_W-1:0] exp_r;
  logic [MAN_W-1:0] man_sh_r;
  logic [IW-1:0]    idx_r;
  logic [LW-1:0]    base_r;
  logic [LW-1:0]    low_r;
  logic             m_nz_r;
  logic             phase_r;
  logic             s_lt_r;
  logic             l_lt_r;
  logic             busy_r;
  logic             r_o_r;
  logic             res_r;
  logic             is_zero_r;
`ifdef CHECKFR_CLASS_EN
  logic             is_inf_r;
  logic             is_nan_r;
`endif

  logic [SCAN_W-1:0] chunk_s;
  logic [PW-1:0]     pos_s;
  logic              hit_s;
  logic [DW-1:0]     s_s;
  logic              s_lt_s;
  logic              l_lt_s;
  logic              exp_zero_s;
  logic              exp_ge_bias_s;
  logic              dec_res_s;
  logic              dec_zero_s;
`ifdef CHECKFR_CLASS_EN
  logic              exp_ones_s;
  logic              dec_inf_s;
  logic              dec_nan_s;
`endif

  // The sign never affects the classification.
  logic unused_sign_s;
  assign unused_sign_s = num_in[EXP_W+MAN_W];

  // The mantissa shifts right each SCAN cycle, so the current chunk always
  // sits at the bottom. Bits past MAN_W arrive as zeros and cannot match.
  assign chunk_s = man_sh_r[SCAN_W-1:0];
  assign hit_s   = |chunk_s;

  // Lowest set bit inside the current chunk; the downward loop leaves the
  // smallest index in pos_s.
  always_comb begin
    pos_s = {PW{1'b0}};
    for (int i = SCAN_W - 1; i >= 0; i--) begin
      if (chunk_s[i]) begin
        pos_s = PW'(i);
      end else begin
        pos_s = pos_s;
      end
    end
  end

  // Exponent terms. s is only meaningful when E >= B.
  // l_lt_s is only used together with s_lt_s, which keeps MAN_W - s from
  // wrapping when it matters.
  assign exp_zero_s    = (exp_r == {EXP_W{1'b0}});
  assign exp_ge_bias_s = (exp_r >= BIAS);
  assign s_s           = DW'(exp_r) - DW'(BIAS);
  assign s_lt_s        = (s_s < MAN_W_D);
  assign l_lt_s        = (DW'(low_r) < (MAN_W_D - s_s));
`ifdef CHECKFR_CLASS_EN
  assign exp_ones_s    = &exp_r;
`endif

  // Final classification, using the comparison terms registered in the
  // first DECIDE cycle.
  always_comb begin
    dec_res_s  = 1'b0;
    dec_zero_s = 1'b0;
    if (exp_zero_s && !m_nz_r) begin
      dec_zero_s = 1'b1;
    end else if (exp_zero_s || !exp_ge_bias_s) begin
      dec_res_s = 1'b1;
    end else if (!m_nz_r) begin
      dec_res_s = 1'b0;
    end else begin
      dec_res_s = s_lt_r && l_lt_r;
    end
`ifdef CHECKFR_CLASS_EN
    dec_inf_s = 1'b0;
    dec_nan_s = 1'b0;
    if (exp_ones_s) begin
      dec_res_s = 1'b0;
      dec_inf_s = !m_nz_r;
      dec_nan_s = m_nz_r;
    end else begin
      dec_inf_s = 1'b0;
      dec_nan_s = 1'b0;
    end
`endif
  end

  // Control FSM, scan datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      exp_r     <= {EXP_W{1'b0}};
      man_sh_r  <= {MAN_W{1'b0}};
      idx_r     <= {IW{1'b0}};
      base_r    <= {LW{1'b0}};
      low_r     <= {LW{1'b0}};
      m_nz_r    <= 1'b0;
      phase_r   <= 1'b0;
      s_lt_r    <= 1'b0;
      l_lt_r    <= 1'b0;
      busy_r    <= 1'b0;
      r_o_r     <= 1'b0;
      res_r     <= 1'b0;
      is_zero_r <= 1'b0;
`ifdef CHECKFR_CLASS_EN
      is_inf_r  <= 1'b0;
      is_nan_r  <= 1'b0;
`endif
    end else begin
      r_o_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (r_i) begin
            exp_r    <= num_in[EXP_W+MAN_W-1:MAN_W];
            man_sh_r <= num_in[MAN_W-1:0];
            idx_r    <= {IW{1'b0}};
            base_r   <= {LW{1'b0}};
            low_r    <= {LW{1'b0}};
            m_nz_r   <= 1'b0;
            phase_r  <= 1'b0;
            busy_r   <= 1'b1;
            state_r  <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Only the first hit is kept; later chunks hold higher indices.
          if (hit_s && !m_nz_r) begin
            low_r  <= base_r + LW'(pos_s);
            m_nz_r <= 1'b1;
          end
          man_sh_r <= man_sh_r >> SCAN_W;
          base_r   <= base_r + STEP;
          idx_r    <= idx_r + IW'(1'b1);
          if (idx_r == IDX_LAST) begin
            state_r <= ST_DECIDE;
          end
        end
        ST_DECIDE: begin
          if (!phase_r) begin
            phase_r <= 1'b1;
            s_lt_r  <= s_lt_s;
            l_lt_r  <= l_lt_s;
          end else begin
            phase_r   <= 1'b0;
            res_r     <= dec_res_s;
            is_zero_r <= dec_zero_s;
`ifdef CHECKFR_CLASS_EN
            is_inf_r  <= dec_inf_s;
            is_nan_r  <= dec_nan_s;
`endif
            r_o_r     <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          phase_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_r;
  assign r_o     = r_o_r;
  assign res     = res_r;
  assign is_zero = is_zero_r;
`ifdef CHECKFR_CLASS_EN
  assign is_inf  = is_inf_r;
  assign is_nan  = is_nan_r;
`endif

endmodule
